// File: rtl/riscv_mc_ctrl_pkg.sv
// rtl/riscv_mc_ctrl_pkg.sv - shared encodings for the multicycle RV32I control unit
// The HALT state exists only when RISCV_MC_ILLEGAL_HALT_EN is defined.
package riscv_mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXER   = 4'd6,
    S_EXEI   = 4'd7,
    S_LUI    = 4'd8,
    S_ALUWB  = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_BR     = 4'd12
`ifdef RISCV_MC_ILLEGAL_HALT_EN
    , S_HALT = 4'd13
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:         return IMM_S;
      OP_BR:            return IMM_B;
      OP_LUI, OP_AUIPC: return IMM_U;
      OP_JAL:           return IMM_J;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_aludec.sv
// rtl/riscv_mc_aludec.sv - ALU decoder: op class, funct3, funct7[5] and opcode[5] to ALU code
module riscv_mc_aludec
  import riscv_mc_ctrl_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  input  logic       i_op5,
  output logic [3:0] o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // Immediate forms have op5=0, so ADDI never turns into SUB.
          3'b000:  o_alu_ctrl = (i_op5 && i_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_ctrl = ALU_SLL;
          3'b010:  o_alu_ctrl = ALU_SLT;
          3'b011:  o_alu_ctrl = ALU_SLTU;
          3'b100:  o_alu_ctrl = ALU_XOR;
          3'b101:  o_alu_ctrl = i_funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_ctrl = ALU_OR;
          default: o_alu_ctrl = ALU_AND;
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// rtl/riscv_mc_ctrl.sv - multicycle RV32I control FSM with memory-ready stalls
// Optional RISCV_MC_ILLEGAL_HALT_EN: illegal instructions trap to a sticky HALT state.
module riscv_mc_ctrl
  import riscv_mc_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  input  logic       i_zero,
  input  logic       i_lt,
  input  logic       i_ltu,
  input  logic       i_mem_ready,
  output logic       o_pc_wr_en,
  output logic       o_adr_src,
  output logic       o_mem_rd_en,
  output logic       o_mem_wr_en,
  output logic       o_ir_wr_en,
  output logic       o_reg_wr_en,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_imm_src,
  output logic [3:0] o_alu_ctrl,
  output logic       o_illegal,
  output logic [3:0] o_state
);

`ifdef RISCV_MC_ILLEGAL_HALT_EN
  localparam state_t S_TRAP = S_HALT;
`else
  localparam state_t S_TRAP = S_FETCH;
`endif

  state_t  state, state_next;
  alu_op_t alu_op;
  logic    taken;
  logic    pc_wr, mem_rd, mem_wr, ir_wr, reg_wr;

  always_comb begin
    case (i_funct3)
      3'b000:  taken = i_zero;
      3'b001:  taken = !i_zero;
      3'b100:  taken = i_lt;
      3'b101:  taken = !i_lt;
      3'b110:  taken = i_ltu;
      3'b111:  taken = !i_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= S_FETCH;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pc_wr        = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    ir_wr        = 1'b0;
    reg_wr       = 1'b0;
    o_adr_src    = 1'b0;
    o_result_src = RES_ALUOUT;
    o_alu_src_a  = SRCA_PC;
    o_alu_src_b  = SRCB_B;
    alu_op       = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_rd       = 1'b1;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALU;
        if (i_mem_ready) begin
          ir_wr      = 1'b1;
          pc_wr      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut picks up OldPC+imm here, so AUIPC can write back directly.
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_IMM;
        case (i_opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXER;
          OP_I:              state_next = S_EXEI;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_ALUWB;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_BR:             state_next = S_BR;
          OP_FENCE:          state_next = S_FETCH;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        o_alu_src_a = SRCA_A;
        o_alu_src_b = SRCB_IMM;
        state_next  = i_opcode[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        o_adr_src = 1'b1;
        mem_rd    = 1'b1;
        if (i_mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_result_src = RES_MDR;
        reg_wr       = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWR: begin
        o_adr_src = 1'b1;
        mem_wr    = 1'b1;
        if (i_mem_ready) state_next = S_FETCH;
      end
      S_EXER: begin
        o_alu_src_a = SRCA_A;
        o_alu_src_b = SRCB_B;
        alu_op      = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end
      S_EXEI: begin
        o_alu_src_a = SRCA_A;
        o_alu_src_b = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end
      S_LUI: begin
        o_alu_src_a = SRCA_ZERO;
        o_alu_src_b = SRCB_IMM;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        o_result_src = RES_ALUOUT;
        reg_wr       = 1'b1;
        state_next   = S_FETCH;
      end
      S_JALR: begin
        o_alu_src_a = SRCA_A;
        o_alu_src_b = SRCB_IMM;
        state_next  = S_JAL;
      end
      S_JAL: begin
        // Redirect PC from ALUOut while the ALU forms the link value OldPC+4.
        o_result_src = RES_ALUOUT;
        pc_wr        = 1'b1;
        o_alu_src_a  = SRCA_OLDPC;
        o_alu_src_b  = SRCB_FOUR;
        state_next   = S_ALUWB;
      end
      S_BR: begin
        o_alu_src_a  = SRCA_A;
        o_alu_src_b  = SRCB_B;
        alu_op       = ALUOP_SUB;
        o_result_src = RES_ALUOUT;
        pc_wr        = taken;
`ifdef RISCV_MC_ILLEGAL_HALT_EN
        state_next   = (i_funct3[2:1] == 2'b01) ? S_HALT : S_FETCH;
`else
        state_next   = S_FETCH;
`endif
      end
`ifdef RISCV_MC_ILLEGAL_HALT_EN
      S_HALT: state_next = S_HALT;
`endif
      default: state_next = S_FETCH;
    endcase
  end

  riscv_mc_aludec u_aludec (
    .i_alu_op   (alu_op),
    .i_funct3   (i_funct3),
    .i_funct7_5 (i_funct7_5),
    .i_op5      (i_opcode[5]),
    .o_alu_ctrl (o_alu_ctrl)
  );

  // Gating with reset drops any in-flight request in the same cycle.
  assign o_pc_wr_en  = pc_wr  & i_rstn;
  assign o_mem_rd_en = mem_rd & i_rstn;
  assign o_mem_wr_en = mem_wr & i_rstn;
  assign o_ir_wr_en  = ir_wr  & i_rstn;
  assign o_reg_wr_en = reg_wr & i_rstn;
  assign o_imm_src   = imm_src_of(i_opcode);
  assign o_state     = state;

`ifdef RISCV_MC_ILLEGAL_HALT_EN
  logic illegal_q;
  always_ff @(posedge i_clk) begin
    if (!i_rstn)                    illegal_q <= 1'b0;
    else if (state_next == S_HALT)  illegal_q <= 1'b1;
  end
  assign o_illegal = illegal_q;
`else
  assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb/tb_riscv_mc_ctrl.sv - self-checking bench for riscv_mc_ctrl
module tb_riscv_mc_ctrl;
  import riscv_mc_ctrl_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic [6:0] i_opcode = '0;
  logic [2:0] i_funct3 = '0;
  logic       i_funct7_5 = 1'b0;
  logic       i_zero = 1'b0, i_lt = 1'b0, i_ltu = 1'b0;
  logic       i_mem_ready = 1'b0;
  logic       o_pc_wr_en, o_adr_src, o_mem_rd_en, o_mem_wr_en, o_ir_wr_en, o_reg_wr_en;
  logic [1:0] o_result_src, o_alu_src_a, o_alu_src_b;
  logic [2:0] o_imm_src;
  logic [3:0] o_alu_ctrl;
  logic       o_illegal;
  logic [3:0] o_state;

  always #5 i_clk = ~i_clk;

  riscv_mc_ctrl dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_funct7_5(i_funct7_5), .i_zero(i_zero), .i_lt(i_lt), .i_ltu(i_ltu),
    .i_mem_ready(i_mem_ready), .o_pc_wr_en(o_pc_wr_en), .o_adr_src(o_adr_src),
    .o_mem_rd_en(o_mem_rd_en), .o_mem_wr_en(o_mem_wr_en), .o_ir_wr_en(o_ir_wr_en),
    .o_reg_wr_en(o_reg_wr_en), .o_result_src(o_result_src), .o_alu_src_a(o_alu_src_a),
    .o_alu_src_b(o_alu_src_b), .o_imm_src(o_imm_src), .o_alu_ctrl(o_alu_ctrl),
    .o_illegal(o_illegal), .o_state(o_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  int         obs_cycles, obs_rd, obs_wr, obs_reg_wr, obs_reg_idx, obs_pc_wr, obs_pc_idx;
  int         obs_ir_wr, obs_imm_bad;
  logic [1:0] obs_reg_rs, obs_pc_rs;
  logic [3:0] obs_alu;
  bit         obs_fetch_ok, obs_timeout, obs_ill;
  logic [3:0] obs_st [0:39];

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b0110111, 7'b0010111: return 3'b011;
      7'b1101111:             return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] exp_alu_of(input logic [2:0] f3, input logic f75, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f75) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f75 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic bit exp_taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Memory responder plus observer: holds ready low for fw cycles of the fetch and
  // mw cycles of the data access, and records what the controller did.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic z, input logic lt, input logic ltu,
                           input int fw, input int mw);
    int wait_left;
    bit fetched;
    wait_left = fw; fetched = 1'b0;
    obs_cycles = 0; obs_rd = 0; obs_wr = 0; obs_reg_wr = 0; obs_reg_idx = -1;
    obs_pc_wr = 0; obs_pc_idx = -1; obs_ir_wr = 0; obs_imm_bad = 0;
    obs_reg_rs = 2'b11; obs_pc_rs = 2'b11; obs_alu = 4'hf;
    obs_fetch_ok = 1'b0; obs_timeout = 1'b1; obs_ill = 1'b0;
    i_opcode = op; i_funct3 = f3; i_funct7_5 = f75; i_zero = z; i_lt = lt; i_ltu = ltu;
    for (int c = 0; c < 40; c++) begin
      i_mem_ready = (wait_left == 0);
      @(negedge i_clk);
      obs_st[c] = o_state;
      if (o_imm_src !== exp_imm(op)) obs_imm_bad++;
      if (o_illegal) obs_ill = 1'b1;
      if (c == 0)
        obs_fetch_ok = o_mem_rd_en && !o_adr_src && o_alu_src_a == 2'b00 &&
                       o_alu_src_b == 2'b10 && o_result_src == 2'b10 && o_alu_ctrl == ALU_ADD;
      if (c == fw + 2) obs_alu = o_alu_ctrl;
      if (o_mem_rd_en) obs_rd++;
      if (o_mem_wr_en) obs_wr++;
      if (o_ir_wr_en) obs_ir_wr++;
      if (o_mem_rd_en || o_mem_wr_en) begin
        if (!i_mem_ready) wait_left--;
        else if (!fetched) begin fetched = 1'b1; wait_left = mw; end
      end
      if (o_reg_wr_en) begin obs_reg_wr++; obs_reg_idx = c; obs_reg_rs = o_result_src; end
      if (o_pc_wr_en) begin
        obs_pc_wr++;
        if (!o_ir_wr_en) begin obs_pc_idx = c; obs_pc_rs = o_result_src; end
      end
      @(posedge i_clk); #1;
      obs_cycles = c + 1;
      if (fetched && o_state == 4'(S_FETCH)) begin obs_timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_mem_ready = 1'b1; i_opcode = 7'b0100011;
    repeat (3) begin
      @(negedge i_clk);
      n_checks++;
      if ({o_pc_wr_en, o_mem_rd_en, o_mem_wr_en, o_ir_wr_en, o_reg_wr_en} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_enables got %b want 00000", {o_pc_wr_en, o_mem_rd_en, o_mem_wr_en, o_ir_wr_en, o_reg_wr_en});
      end
    end
    n_checks++;
    if (o_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", o_illegal); end
    @(posedge i_clk); #1;
    i_rstn = 1'b1; i_mem_ready = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if (o_state !== 4'(S_FETCH) || o_mem_rd_en !== 1'b1 || o_adr_src !== 1'b0 || o_ir_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fetch got state=%0d rd=%b adr=%b ir=%b want state=%0d rd=1 adr=0 ir=0",
               o_state, o_mem_rd_en, o_adr_src, o_ir_wr_en, S_FETCH);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_add();
    logic [3:0] exp_st [0:3];
    exp_st[0] = S_FETCH; exp_st[1] = S_DECODE; exp_st[2] = S_EXER; exp_st[3] = S_ALUWB;
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (obs_cycles !== 4 || obs_timeout) begin n_fail++; $display("FAIL add_cycles got %0d want 4", obs_cycles); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_st[i] !== exp_st[i]) begin n_fail++; $display("FAIL add_state%0d got %0d want %0d", i, obs_st[i], exp_st[i]); end
    end
    n_checks++;
    if (obs_reg_wr !== 1 || obs_reg_idx !== 3 || obs_reg_rs !== 2'b00) begin
      n_fail++;
      $display("FAIL add_regwr got n=%0d idx=%0d rs=%b want n=1 idx=3 rs=00", obs_reg_wr, obs_reg_idx, obs_reg_rs);
    end
    n_checks++;
    if (obs_alu !== ALU_ADD) begin n_fail++; $display("FAIL add_alu got %0d want %0d", obs_alu, ALU_ADD); end
    n_checks++;
    if (!obs_fetch_ok) begin n_fail++; $display("FAIL add_fetch_ctrl got 0 want 1"); end
  endtask

  task automatic test_load_wait();
    int n_memrd;
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2);
    n_memrd = 0;
    for (int i = 0; i < obs_cycles; i++) if (obs_st[i] == 4'(S_MEMRD)) n_memrd++;
    n_checks++;
    if (obs_cycles !== 7 || obs_timeout) begin n_fail++; $display("FAIL load_cycles got %0d want 7", obs_cycles); end
    n_checks++;
    if (n_memrd !== 3) begin n_fail++; $display("FAIL load_memrd_len got %0d want 3", n_memrd); end
    n_checks++;
    if (obs_reg_wr !== 1 || obs_reg_idx !== 6 || obs_reg_rs !== 2'b01) begin
      n_fail++;
      $display("FAIL load_wb got n=%0d idx=%0d rs=%b want n=1 idx=6 rs=01", obs_reg_wr, obs_reg_idx, obs_reg_rs);
    end
  endtask

  task automatic test_branch();
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (obs_cycles !== 3 || obs_pc_wr !== 2 || obs_pc_idx !== 2 || obs_pc_rs !== 2'b00) begin
      n_fail++;
      $display("FAIL beq_taken got cyc=%0d pcw=%0d idx=%0d rs=%b want cyc=3 pcw=2 idx=2 rs=00",
               obs_cycles, obs_pc_wr, obs_pc_idx, obs_pc_rs);
    end
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (obs_cycles !== 3 || obs_pc_wr !== 1 || obs_reg_wr !== 0) begin
      n_fail++;
      $display("FAIL bne_not_taken got cyc=%0d pcw=%0d regw=%0d want cyc=3 pcw=1 regw=0", obs_cycles, obs_pc_wr, obs_reg_wr);
    end
  endtask

  task automatic test_jalr();
    logic [3:0] exp_st [0:4];
    exp_st[0] = S_FETCH; exp_st[1] = S_DECODE; exp_st[2] = S_JALR; exp_st[3] = S_JAL; exp_st[4] = S_ALUWB;
    run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs_st[i] !== exp_st[i]) begin n_fail++; $display("FAIL jalr_state%0d got %0d want %0d", i, obs_st[i], exp_st[i]); end
    end
    n_checks++;
    if (obs_pc_idx !== 3 || obs_pc_rs !== 2'b00 || obs_reg_idx !== 4 || obs_reg_wr !== 1) begin
      n_fail++;
      $display("FAIL jalr_writes got pc_idx=%0d rs=%b reg_idx=%0d n=%0d want pc_idx=3 rs=00 reg_idx=4 n=1",
               obs_pc_idx, obs_pc_rs, obs_reg_idx, obs_reg_wr);
    end
  endtask

  task automatic test_illegal();
`ifdef RISCV_MC_ILLEGAL_HALT_EN
    i_opcode = 7'b1111111; i_mem_ready = 1'b1;
    @(negedge i_clk); @(posedge i_clk); #1;
    @(negedge i_clk);
    n_checks++;
    if (o_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_early got %b want 0", o_illegal); end
    @(posedge i_clk); #1;
    for (int i = 0; i < 10; i++) begin
      i_mem_ready = 1'($urandom);
      @(negedge i_clk);
      n_checks++;
      if (o_state !== 4'(S_HALT) || o_illegal !== 1'b1 ||
          {o_pc_wr_en, o_mem_rd_en, o_mem_wr_en, o_ir_wr_en, o_reg_wr_en} !== 5'b0) begin
        n_fail++;
        $display("FAIL halt_cycle%0d got state=%0d ill=%b en=%b want state=%0d ill=1 en=00000", i, o_state, o_illegal,
                 {o_pc_wr_en, o_mem_rd_en, o_mem_wr_en, o_ir_wr_en, o_reg_wr_en}, S_HALT);
      end
      @(posedge i_clk); #1;
    end
    i_rstn = 1'b0;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    n_checks++;
    if (o_illegal !== 1'b0 || o_state !== 4'(S_FETCH)) begin
      n_fail++;
      $display("FAIL halt_reset got ill=%b state=%0d want ill=0 state=%0d", o_illegal, o_state, S_FETCH);
    end
`else
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (obs_cycles !== 2 || obs_st[1] !== 4'(S_DECODE) || obs_timeout) begin
      n_fail++;
      $display("FAIL illegal_nop got cyc=%0d st1=%0d want cyc=2 st1=%0d", obs_cycles, obs_st[1], S_DECODE);
    end
    n_checks++;
    if (obs_reg_wr !== 0 || obs_pc_wr !== 1 || obs_wr !== 0 || obs_ill !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_writes got regw=%0d pcw=%0d memw=%0d ill=%b want 0 1 0 0", obs_reg_wr, obs_pc_wr, obs_wr, obs_ill);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    seen = 1'b0;
    i_opcode = 7'b0100011; i_funct3 = 3'b010; i_mem_ready = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge i_clk);
      if (o_mem_wr_en) seen = 1'b1;
      @(posedge i_clk); #1;
      i_mem_ready = 1'b0;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_mid_reach got no write want write request"); end
    i_rstn = 1'b0;
    #1;
    n_checks++;
    if (o_mem_wr_en !== 1'b0 || o_mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drop got wr=%b rd=%b want wr=0 rd=0", o_mem_wr_en, o_mem_rd_en);
    end
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_state !== 4'(S_FETCH) || o_mem_rd_en !== 1'b1 || o_adr_src !== 1'b0 || o_mem_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_fetch got state=%0d rd=%b adr=%b wr=%b want state=%0d rd=1 adr=0 wr=0",
               o_state, o_mem_rd_en, o_adr_src, o_mem_wr_en, S_FETCH);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_random();
    logic [6:0] ops [0:10];
    int         n_ops, base, exp_cycles, exp_rd, exp_wr, pc_back;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75, z, lt, ltu, is_ld, is_st, wr_rd, alu_chk;
    logic [3:0] exp_alu;
    int         fw, mw;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
            7'b1101111, 7'b1100111, 7'b1100011, 7'b0001111, 7'b1111111};
`ifdef RISCV_MC_ILLEGAL_HALT_EN
    n_ops = 10;
`else
    n_ops = 11;
`endif
    for (int k = 0; k < 60; k++) begin
      op = ops[$urandom_range(0, n_ops - 1)];
      f3 = 3'($urandom); f75 = 1'($urandom);
      z = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
`ifdef RISCV_MC_ILLEGAL_HALT_EN
      if (op == 7'b1100011 && f3[2:1] == 2'b01) f3[2] = 1'b1;
`endif
      fw = $urandom_range(0, 2); mw = $urandom_range(0, 2);
      base = 2; is_ld = 0; is_st = 0; wr_rd = 0; pc_back = 0; alu_chk = 0; exp_alu = ALU_ADD;
      case (op)
        7'b0000011: begin base = 5; is_ld = 1; wr_rd = 1; alu_chk = 1; end
        7'b0100011: begin base = 4; is_st = 1; alu_chk = 1; end
        7'b0110011: begin base = 4; wr_rd = 1; alu_chk = 1; exp_alu = exp_alu_of(f3, f75, 1'b1); end
        7'b0010011: begin base = 4; wr_rd = 1; alu_chk = 1; exp_alu = exp_alu_of(f3, f75, 1'b0); end
        7'b0110111: begin base = 4; wr_rd = 1; alu_chk = 1; end
        7'b0010111: begin base = 3; wr_rd = 1; end
        7'b1101111: begin base = 4; wr_rd = 1; pc_back = 2; end
        7'b1100111: begin base = 5; wr_rd = 1; pc_back = 2; alu_chk = 1; end
        7'b1100011: begin base = 3; alu_chk = 1; exp_alu = ALU_SUB; pc_back = exp_taken(f3, z, lt, ltu) ? 1 : 0; end
        default:    base = 2;
      endcase
      exp_cycles = base + fw + ((is_ld || is_st) ? mw : 0);
      exp_rd = fw + 1 + (is_ld ? mw + 1 : 0);
      exp_wr = is_st ? mw + 1 : 0;
      run_instr(op, f3, f75, z, lt, ltu, fw, mw);
      n_checks++;
      if (obs_cycles !== exp_cycles || obs_timeout) begin
        n_fail++; $display("FAIL rnd%0d op=%b cycles got %0d want %0d", k, op, obs_cycles, exp_cycles);
      end
      n_checks++;
      if (obs_rd !== exp_rd || obs_wr !== exp_wr || obs_ir_wr !== 1) begin
        n_fail++;
        $display("FAIL rnd%0d op=%b mem got rd=%0d wr=%0d ir=%0d want rd=%0d wr=%0d ir=1", k, op, obs_rd, obs_wr, obs_ir_wr, exp_rd, exp_wr);
      end
      n_checks++;
      if (obs_reg_wr !== (wr_rd ? 1 : 0) ||
          (wr_rd && (obs_reg_idx !== exp_cycles - 1 || obs_reg_rs !== (is_ld ? 2'b01 : 2'b00)))) begin
        n_fail++;
        $display("FAIL rnd%0d op=%b regwr got n=%0d idx=%0d rs=%b want n=%0d idx=%0d", k, op, obs_reg_wr, obs_reg_idx,
                 obs_reg_rs, wr_rd ? 1 : 0, exp_cycles - 1);
      end
      n_checks++;
      if (obs_pc_wr !== (pc_back != 0 ? 2 : 1) ||
          (pc_back != 0 && (obs_pc_idx !== exp_cycles - pc_back || obs_pc_rs !== 2'b00))) begin
        n_fail++;
        $display("FAIL rnd%0d op=%b f3=%b pcwr got n=%0d idx=%0d rs=%b want n=%0d idx=%0d", k, op, f3, obs_pc_wr,
                 obs_pc_idx, obs_pc_rs, pc_back != 0 ? 2 : 1, exp_cycles - pc_back);
      end
      n_checks++;
      if (obs_imm_bad !== 0 || !obs_fetch_ok || obs_ill !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd%0d op=%b misc got immbad=%0d fetch_ok=%b ill=%b want 0 1 0", k, op, obs_imm_bad, obs_fetch_ok, obs_ill);
      end
      if (alu_chk) begin
        n_checks++;
        if (obs_alu !== exp_alu) begin
          n_fail++; $display("FAIL rnd%0d op=%b f3=%b f7=%b alu got %0d want %0d", k, op, f3, f75, obs_alu, exp_alu);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_jalr();
    test_illegal();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
